// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg
// Shared definitions for the multi-port register file.
//   - Default geometry constants (data width, address width, depth).
//   - Clear-engine FSM state encoding.
package regfile_mp_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DEPTH      = 32;

  // IDLE is the normal operating state. CLEAR sweeps zeros through the array.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_mp_read_port.sv
// rf_read_port
// One combinational read port with write-first bypass.
// Ports:
//   busy            in  clear sweep in progress; forces the read to zero
//   raddr           in  read address
//   acc_a / acc_b   in  port A / port B write accepted this cycle
//   waddr_a/_b      in  write addresses
//   wdata_a/_b      in  write data
//   mem_data        in  array contents at raddr
//   rdata           out selected read data
module rf_read_port
  import regfile_mp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter bit ZERO_REG   = 1'b0
) (
  input  logic                  busy,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  acc_a,
  input  logic [ADDR_WIDTH-1:0] waddr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  input  logic                  acc_b,
  input  logic [ADDR_WIDTH-1:0] waddr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] rdata
);

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  logic in_range;
  assign in_range = ({1'b0, raddr} < DEPTH_W);

  // Port B is checked before port A so that a same-address double write
  // bypasses the value that will actually be stored.
  always_comb begin
    rdata = mem_data;
    if (busy || !in_range || (ZERO_REG && raddr == '0)) begin
      rdata = '0;
    end else if (acc_b && waddr_b == raddr) begin
      rdata = wdata_b;
    end else if (acc_a && waddr_a == raddr) begin
      rdata = wdata_a;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Parametrised register file: NUM_RD combinational read ports, two write
// ports (B wins on address collision), write-first bypass, optional hardwired
// zero register, and a sequential clear engine run after reset or on request.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   clr_req           start a clear sweep (honoured in IDLE only)
//   busy              clear sweep in progress
//   we_a/waddr_a/wdata_a   write port A
//   we_b/waddr_b/wdata_b   write port B (priority)
//   raddr / rdata     packed read addresses / data, port k at slice k
//   wr_conflict       pulse: A and B wrote the same address last cycle
//   wr_drop           pulse: a write was discarded last cycle
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int NUM_RD     = 3,
  parameter bit ZERO_REG   = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_req,
  output logic                         busy,
  input  logic                         we_a,
  input  logic [ADDR_WIDTH-1:0]        waddr_a,
  input  logic [DATA_WIDTH-1:0]        wdata_a,
  input  logic                         we_b,
  input  logic [ADDR_WIDTH-1:0]        waddr_b,
  input  logic [DATA_WIDTH-1:0]        wdata_b,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic                         wr_conflict,
  output logic                         wr_drop
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH-1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  rf_state_t             state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_ptr, clr_ptr_nxt;

  logic acc_a, acc_b;
  logic drop_nxt, conflict_nxt;

  assign busy = (state == CLEAR);

  // A write is accepted only in IDLE, in range, not to a hardwired zero
  // register, and never while reset is being sampled.
  assign acc_a = rst && we_a && (state == IDLE) && ({1'b0, waddr_a} < DEPTH_W)
                 && !(ZERO_REG && waddr_a == '0);
  assign acc_b = rst && we_b && (state == IDLE) && ({1'b0, waddr_b} < DEPTH_W)
                 && !(ZERO_REG && waddr_b == '0);

  assign conflict_nxt = acc_a && acc_b && (waddr_a == waddr_b);
  assign drop_nxt     = (we_a && !acc_a) || (we_b && !acc_b);

  // Clear FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // Next-state: the sweep leaves CLEAR after writing the last entry, and the
  // pointer is parked at zero in IDLE so a new sweep always starts from 0.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    unique case (state)
      CLEAR: begin
        if (clr_ptr == LAST_PTR) begin
          state_nxt   = IDLE;
          clr_ptr_nxt = '0;
        end else begin
          clr_ptr_nxt = clr_ptr + 1'b1;
        end
      end
      IDLE: begin
        if (clr_req) begin
          state_nxt   = CLEAR;
          clr_ptr_nxt = '0;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_ptr_nxt = '0;
      end
    endcase
  end

  // Array update. Port B is written after port A so it wins on collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == CLEAR) begin
        mem[clr_ptr] <= '0;
      end else begin
        if (acc_a) mem[waddr_a] <= wdata_a;
        if (acc_b) mem[waddr_b] <= wdata_b;
      end
    end
  end

  // Status pulses, cleared by reset so writes seen during reset never flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_conflict <= 1'b0;
      wr_drop     <= 1'b0;
    end else begin
      wr_conflict <= conflict_nxt;
      wr_drop     <= drop_nxt;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [DATA_WIDTH-1:0] mem_rd;
    assign mem_rd = mem[raddr[k*ADDR_WIDTH +: ADDR_WIDTH]];

    rf_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH),
      .ZERO_REG   (ZERO_REG)
    ) u_rd (
      .busy     (busy),
      .raddr    (raddr[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .acc_a    (acc_a),
      .waddr_a  (waddr_a),
      .wdata_a  (wdata_a),
      .acc_b    (acc_b),
      .waddr_b  (waddr_b),
      .wdata_b  (wdata_b),
      .mem_data (mem_rd),
      .rdata    (rdata[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Directed bench for regfile_mp. Two instances share the stimulus:
//   dut0: 32 x 16, 3 read ports, ZERO_REG=0
//   dut1: 24 x 16, 2 read ports, ZERO_REG=1 (exercises zero register and
//         out-of-range addresses)
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_req;
  logic        we_a, we_b;
  logic [4:0]  waddr_a, waddr_b;
  logic [15:0] wdata_a, wdata_b;
  logic [14:0] raddr;
  logic [9:0]  raddr1;
  logic [47:0] rdata0;
  logic [31:0] rdata1;
  logic        busy0, busy1;
  logic        conf0, conf1;
  logic        drop0, drop1;

  int total = 0;
  int bad   = 0;
  int c0, c1;

  assign raddr1 = raddr[9:0];

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_WIDTH(16), .ADDR_WIDTH(5), .DEPTH(32), .NUM_RD(3), .ZERO_REG(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy0),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .raddr(raddr), .rdata(rdata0),
    .wr_conflict(conf0), .wr_drop(drop0)
  );

  regfile_mp #(
    .DATA_WIDTH(16), .ADDR_WIDTH(5), .DEPTH(24), .NUM_RD(2), .ZERO_REG(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .raddr(raddr1), .rdata(rdata1),
    .wr_conflict(conf1), .wr_drop(drop1)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wa, input logic [4:0] aa, input logic [15:0] da,
                               input logic wb, input logic [4:0] ab, input logic [15:0] db);
    we_a = wa; waddr_a = aa; wdata_a = da;
    we_b = wb; waddr_b = ab; wdata_b = db;
    #1;
  endtask

  task automatic setRead(input int k, input logic [4:0] a);
    raddr[k*5 +: 5] = a;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [47:0] got, input logic [47:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rd0(input int k);
    return rdata0[k*16 +: 16];
  endfunction

  function automatic logic [15:0] rd1(input int k);
    return rdata1[k*16 +: 16];
  endfunction

  // Counts busy cycles of both instances until dut0 returns to IDLE.
  task automatic countSweep(output int n0, output int n1);
    int i;
    n0 = 0; n1 = 0; i = 0;
    while (busy0 && i < 100) begin
      n0++;
      if (busy1) n1++;
      tick();
      i++;
    end
  endtask

  initial begin
    rst = 1'b0; clr_req = 1'b0; raddr = '0;
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Reset held low for two cycles.
    tick(); tick();
    checkOutput("rst_busy0", 48'(busy0), 48'h1);
    checkOutput("rst_busy1", 48'(busy1), 48'h1);
    checkOutput("rst_conf", 48'(conf0), 48'h0);
    checkOutput("rst_drop", 48'(drop0), 48'h0);
    checkOutput("rst_rdata0", rdata0, 48'h0);
    rst = 1'b1;
    #1;
    checkOutput("sweep_rdata0", rdata0, 48'h0);
    checkOutput("sweep_rdata1", 48'(rdata1), 48'h0);
    countSweep(c0, c1);
    checkOutput("rst_sweep_len0", 48'(c0), 48'd32);
    checkOutput("rst_sweep_len1", 48'(c1), 48'd24);
    setRead(0, 0); setRead(1, 1); setRead(2, 31);
    checkOutput("post_rst_rdata0", rdata0, 48'h0);
    checkOutput("post_rst_rdata1", 48'(rdata1), 48'h0);

    // Plain write then read.
    applyStimulus(1, 5, 16'h1234, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    setRead(0, 5);
    checkOutput("wr5_dut0", 48'(rd0(0)), 48'h1234);
    checkOutput("wr5_dut1", 48'(rd1(0)), 48'h1234);

    // Same-cycle bypass on port A.
    setRead(0, 7);
    applyStimulus(1, 7, 16'hBEEF, 0, 0, 0);
    checkOutput("byp7_same", 48'(rd0(0)), 48'hBEEF);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("byp7_next", 48'(rd0(0)), 48'hBEEF);
    tick();
    checkOutput("byp7_later", 48'(rd0(0)), 48'hBEEF);

    // Both ports writing different addresses, both bypassed and stored.
    setRead(1, 8); setRead(2, 9);
    applyStimulus(1, 8, 16'h0A0A, 1, 9, 16'h0B0B);
    checkOutput("byp8_a", 48'(rd0(1)), 48'h0A0A);
    checkOutput("byp9_b", 48'(rd0(2)), 48'h0B0B);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("st8", 48'(rd0(1)), 48'h0A0A);
    checkOutput("st9", 48'(rd0(2)), 48'h0B0B);
    checkOutput("diff_noconf", 48'(conf0), 48'h0);

    // Same-address conflict: B wins, conflict pulses one cycle later.
    setRead(0, 3);
    applyStimulus(1, 3, 16'h1111, 1, 3, 16'h2222);
    checkOutput("conf_byp", 48'(rd0(0)), 48'h2222);
    checkOutput("conf_early", 48'(conf0), 48'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("conf_pulse0", 48'(conf0), 48'h1);
    checkOutput("conf_pulse1", 48'(conf1), 48'h1);
    checkOutput("conf_data", 48'(rd0(0)), 48'h2222);
    tick();
    checkOutput("conf_clear", 48'(conf0), 48'h0);

    // Register 0: stored in dut0, hardwired zero in dut1.
    setRead(0, 0);
    applyStimulus(1, 0, 16'hFFFF, 0, 0, 0);
    checkOutput("r0_byp_dut0", 48'(rd0(0)), 48'hFFFF);
    checkOutput("r0_byp_dut1", 48'(rd1(0)), 48'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("r0_drop1", 48'(drop1), 48'h1);
    checkOutput("r0_nodrop0", 48'(drop0), 48'h0);
    checkOutput("r0_st_dut0", 48'(rd0(0)), 48'hFFFF);
    checkOutput("r0_st_dut1", 48'(rd1(0)), 48'h0);
    tick();
    checkOutput("r0_drop_end", 48'(drop1), 48'h0);

    // Address beyond DEPTH for dut1 only.
    setRead(0, 26);
    applyStimulus(0, 0, 0, 1, 26, 16'h5A5A);
    checkOutput("oor_byp_dut0", 48'(rd0(0)), 48'h5A5A);
    checkOutput("oor_byp_dut1", 48'(rd1(0)), 48'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("oor_drop1", 48'(drop1), 48'h1);
    checkOutput("oor_st_dut0", 48'(rd0(0)), 48'h5A5A);

    // Fill every register with its own index.
    for (int i = 0; i < 32; i += 2) begin
      applyStimulus(1, 5'(i), 16'(i), 1, 5'(i + 1), 16'(i + 1));
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      setRead(0, 5'(i));
      checkOutput($sformatf("fill0_%0d", i), 48'(rd0(0)), 48'(i));
      checkOutput($sformatf("fill1_%0d", i), 48'(rd1(0)),
                  (i == 0 || i >= 24) ? 48'h0 : 48'(i));
    end

    // Clear request with a write attempted during the sweep.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    checkOutput("clr_busy", 48'(busy0), 48'h1);
    checkOutput("clr_rd_busy", 48'(rd0(0)), 48'h0);
    c0 = 1; c1 = 1;
    setRead(0, 4);
    applyStimulus(1, 4, 16'hAAAA, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("clr_wr_drop0", 48'(drop0), 48'h1);
    checkOutput("clr_wr_drop1", 48'(drop1), 48'h1);
    begin
      int r0, r1;
      countSweep(r0, r1);
      c0 += r0; c1 += r1;
    end
    checkOutput("clr_len0", 48'(c0), 48'd32);
    checkOutput("clr_len1", 48'(c1), 48'd24);
    for (int i = 0; i < 32; i++) begin
      setRead(0, 5'(i)); setRead(1, 5'(31 - i)); setRead(2, 5'((i + 7) % 32));
      checkOutput($sformatf("clr_zero_%0d", i), rdata0, 48'h0);
    end
    checkOutput("clr_zero_dut1", 48'(rdata1), 48'h0);

    // Reset at sweep cycle 10, with a write presented during reset.
    applyStimulus(1, 6, 16'h6666, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    setRead(0, 6);
    checkOutput("pre_mid_wr6", 48'(rd0(0)), 48'h6666);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    checkOutput("mid_busy", 48'(busy0), 48'h1);
    rst = 1'b0;
    applyStimulus(1, 6, 16'h7777, 0, 0, 0);
    tick();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("mid_rst_busy", 48'(busy0), 48'h1);
    checkOutput("mid_rst_nodrop", 48'(drop0), 48'h0);
    countSweep(c0, c1);
    checkOutput("mid_len0", 48'(c0), 48'd32);
    checkOutput("mid_len1", 48'(c1), 48'd24);
    checkOutput("mid_wr6_cleared", 48'(rd0(0)), 48'h0);
    checkOutput("mid_idle_drop", 48'(drop0), 48'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
